// File: rtl/ycbcr444_to_422_pkg.sv
// Shared types for the 4:4:4 -> 4:2:2 chroma subsampler.
package ycc_pkg;
    localparam int DW_DEF = 10;

    localparam logic CSEL_CB = 1'b0;
    localparam logic CSEL_CR = 1'b1;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DW_DEF-1:0] y;
        logic [DW_DEF-1:0] c;
        logic              c_sel;
        logic              eol;
    } ycc_word_t;
endpackage

// File: rtl/ycbcr444_to_422_fifo.sv
// Output FIFO: two entries written per cycle (or none), one popped per cycle.
module ycc422_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr2,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic [WIDTH-1:0]         wdata1,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic [PW-1:0]    w_wptr1;
    logic [PW:0]      w_inc;
    logic [PW:0]      w_dec;

    assign w_wptr1 = r_wptr + PW'(1);
    assign w_inc   = wr2 ? (PW+1)'(2) : '0;
    assign w_dec   = rd  ? (PW+1)'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (wr2) begin
                r_mem[r_wptr]  <= wdata0;
                r_mem[w_wptr1] <= wdata1;
                r_wptr         <= r_wptr + PW'(2);
            end
            if (rd) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + w_inc - w_dec;
        end
    end

    assign rdata = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign free  = (PW+1)'(DEPTH) - r_count;
endmodule

// File: rtl/ycbcr444_to_422.sv
// 4:4:4 -> 4:2:2: each pixel pair becomes (Y0,Cb) then (Y1,Cr), chroma averaged.
module ycbcr444_to_422
    import ycc_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CHROMA_AVG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_y,
    input  logic [DW-1:0] s_cb,
    input  logic [DW-1:0] s_cr,
    input  logic          s_eol,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_y,
    output logic [DW-1:0] m_c,
    output logic          m_c_sel,
    output logic          m_eol
);
    typedef struct packed {
        logic [DW-1:0] y;
        logic [DW-1:0] c;
        logic          c_sel;
        logic          eol;
    } word_t;

    localparam int WW = $bits(word_t);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_y0, r_cb0, r_cr0;
    logic [DW-1:0] w_cba, w_cra;
    logic [DW:0]   w_cb_sum, w_cr_sum;
    logic          w_room2, w_acc, w_wr2, w_empty, w_rd;
    logic [FW-1:0] w_free;
    word_t         w_word0, w_word1, w_head;

    // DW+1-bit sum keeps the carry; the rounded half always fits in DW bits.
    assign w_cb_sum = {1'b0, r_cb0} + {1'b0, s_cb} + (DW+1)'(1);
    assign w_cr_sum = {1'b0, r_cr0} + {1'b0, s_cr} + (DW+1)'(1);
    assign w_cba    = (CHROMA_AVG != 0) ? w_cb_sum[DW:1] : r_cb0;
    assign w_cra    = (CHROMA_AVG != 0) ? w_cr_sum[DW:1] : r_cr0;

    assign w_room2 = (w_free >= FW'(2));
    assign w_acc   = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_EVEN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        w_wr2       = 1'b0;
        w_word0     = '{y: s_y, c: s_cb, c_sel: CSEL_CB, eol: 1'b0};
        w_word1     = '{y: s_y, c: s_cr, c_sel: CSEL_CR, eol: 1'b1};
        unique case (r_state)
            S_EVEN: begin
                s_ready = !rst && (!s_eol || w_room2);
                if (w_acc) begin
                    // An even pixel with eol ends an odd-length line: pad the pair with itself.
                    if (s_eol) w_wr2 = 1'b1;
                    else       w_state_nxt = S_ODD;
                end
            end
            S_ODD: begin
                s_ready = !rst && w_room2;
                w_word0 = '{y: r_y0, c: w_cba, c_sel: CSEL_CB, eol: 1'b0};
                w_word1 = '{y: s_y,  c: w_cra, c_sel: CSEL_CR, eol: s_eol};
                if (w_acc) begin
                    w_wr2       = 1'b1;
                    w_state_nxt = S_EVEN;
                end
            end
            default: w_state_nxt = S_EVEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y0  <= '0;
            r_cb0 <= '0;
            r_cr0 <= '0;
        end else if (w_acc && r_state == S_EVEN && !s_eol) begin
            r_y0  <= s_y;
            r_cb0 <= s_cb;
            r_cr0 <= s_cr;
        end
    end

    assign w_rd = !w_empty && m_ready;

    ycc422_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr2    (w_wr2),
        .wdata0 (w_word0),
        .wdata1 (w_word1),
        .rd     (w_rd),
        .rdata  (w_head),
        .empty  (w_empty),
        .free   (w_free)
    );

    assign m_valid = !w_empty;
    assign m_y     = w_head.y;
    assign m_c     = w_head.c;
    assign m_c_sel = w_head.c_sel;
    assign m_eol   = w_head.eol;
endmodule
